// File: rtl/writeback_regfile.sv
// MEM/WB pipeline register feeding a 2**ADDR_WIDTH-entry integer register file.
// Two combinational read ports with same-cycle bypass of the pending writeback.
module writeback_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Result,
    input  logic [ADDR_WIDTH-1:0] RdM,
    input  logic                  RegWriteM,
    input  logic                  ValidM,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic [ADDR_WIDTH-1:0] Rs1,
    input  logic [ADDR_WIDTH-1:0] Rs2,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic [DATA_WIDTH-1:0] ResultW,
    output logic [ADDR_WIDTH-1:0] RdW,
    output logic                  WbEn,
    output logic [DATA_WIDTH-1:0] a0
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int A0_IDX   = 10;

    logic [DATA_WIDTH-1:0] result_w_q, result_w_d;
    logic [ADDR_WIDTH-1:0] rd_w_q, rd_w_d;
    logic                  reg_write_w_q, reg_write_w_d;
    logic                  valid_w_q, valid_w_d;
    logic                  wb_en;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    // Flush beats Stall; a flush keeps the data fields and only kills the slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        result_w_d    = result_w_q;
        rd_w_d        = rd_w_q;
        reg_write_w_d = reg_write_w_q;
        valid_w_d     = valid_w_q;
        if (Flush) begin
            reg_write_w_d = 1'b0;
            valid_w_d     = 1'b0;
        end else if (!Stall) begin
            result_w_d    = Result;
            rd_w_d        = RdM;
            reg_write_w_d = RegWriteM;
            valid_w_d     = ValidM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            result_w_q    <= '0;
            rd_w_q        <= '0;
            reg_write_w_q <= 1'b0;
            valid_w_q     <= 1'b0;
        end else begin
            result_w_q    <= result_w_d;
            rd_w_q        <= rd_w_d;
            reg_write_w_q <= reg_write_w_d;
            valid_w_q     <= valid_w_d;
        end
    end

    assign wb_en = valid_w_q & reg_write_w_q & (rd_w_q != '0);

    // The commit uses the pre-edge wb_en, so a same-edge Flush never cancels it.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the array is cleared on reset because software may read registers before writing them.
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[rd_w_q] <= result_w_q;
        end
    end

    always_comb begin
        RD1 = regs_q[Rs1];
        if (Rs1 == '0) begin
            RD1 = '0;
        end else if (wb_en && (rd_w_q == Rs1)) begin
            RD1 = result_w_q;
        end
    end

    always_comb begin
        RD2 = regs_q[Rs2];
        if (Rs2 == '0) begin
            RD2 = '0;
        end else if (wb_en && (rd_w_q == Rs2)) begin
            RD2 = result_w_q;
        end
    end

    assign ResultW = result_w_q;
    assign RdW     = rd_w_q;
    assign WbEn    = wb_en;
    assign a0      = regs_q[A0_IDX];

endmodule
